bus_io_responder: RTL and testbench
===================================

Name: bus_io_responder

Overview:
- Memory-mapped peripheral on the CPU's external data bus, i.e. the responder side of the bus (addr, cs, wr_rd, data_bus_write, data_bus_read).
- Bridges CPU loads/stores to two word FIFOs:
  - TX FIFO: CPU writes, drained by an external valid/ready consumer.
  - RX FIFO: filled by an external valid/ready producer, CPU reads.
- Read data is combinational so the CPU can capture it in the same MEM cycle; all state changes happen on clk.

Parameters:
DEPTH_LOG2, 3, log2 of each FIFO depth (depth 8); legal range 1..6.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
addr  input  32  bus address; only addr[3:2] decoded, other bits ignored
cs  input  1  chip select from address decoder; 1 = this block addressed
wr_rd  input  1  1 = write, 0 = read; sampled only when cs=1
data_bus_write  input  32  store data
data_bus_read  output  32  load data, combinational
out_data  output  32  TX FIFO head
out_valid  output  1  TX FIFO not empty
out_ready  input  1  consumer accepts out_data
in_data  input  32  producer word
in_valid  input  1  producer word present
in_ready  output  1  RX FIFO not full
irq  output  1  interrupt; only with optional feature, otherwise tied 0

Behaviour:
- Register map (addr[3:2]); unused bits read 0:
  - 0 TXDATA: write pushes data_bus_write; reads return 0.
  - 1 RXDATA: read returns RX head (0 if empty) and pops on the clock edge; writes ignored.
  - 2 STATUS, read:
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty
    - bit4 tx_overflow (sticky), bit5 rx_underflow (sticky)
    - bits[8+:DEPTH_LOG2+1] tx_count, bits[16+:DEPTH_LOG2+1] rx_count
  - 2 STATUS, write: write-1-to-clear on bits 4 and 5; other bits ignored.
  - 3 CTRL:
    - bit0 tx_flush, bit1 rx_flush: write 1 empties that FIFO at the edge; self-clearing, read 0.
    - bit2 irq_en: R/W, present only with the optional feature.
- cs=0: no side effects; data_bus_read = 0.
- Bus access is single-cycle with no wait states:
  - Read data is valid in the same cycle as cs.
  - Write and pop effects are visible from the next cycle.
- TX FIFO:
  - CPU write to TXDATA when tx_full: word dropped, tx_overflow set. Applies even if an out handshake occurs the same cycle.
  - out_valid = !tx_empty; pop on out_valid & out_ready.
  - Write into an empty FIFO: out_valid rises the next cycle. There is no bypass.
- RX FIFO:
  - in_ready = !rx_full; push on in_valid & in_ready.
  - RXDATA read when rx_empty: returns 0, no pop, rx_underflow set. A same-cycle in handshake is still stored.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both take effect.
- Flush in the same cycle as push and/or pop on the same FIFO: flush wins, count becomes 0, pushed word discarded.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits, range 0..depth.
- Sticky flag set and W1C clear in the same cycle: set wins.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFOs empty, pointers and counts 0, sticky flags 0, irq_en 0.
  - out_valid=0, in_ready=0 while rst=0, irq=0.
  - After release, in_ready=1 from the first cycle.
  - FIFO storage contents need not be reset.

Optional Feature:
- Macro BUS_IO_RESPONDER_IRQ_EN.
- Defined:
  - CTRL bit2 irq_en is implemented.
  - irq is registered: irq = irq_en & (!rx_empty | tx_overflow | rx_underflow), updated each edge, so it is 1 cycle behind the status.
- Undefined:
  - CTRL bit2 reads 0 and writes are ignored.
  - irq is constant 0.
  - No irq flop is synthesised.

Test Plan:
- Reset, then read STATUS -> data_bus_read = 0x0000000A (tx_empty, rx_empty); in_ready=1; out_valid=0.
- Write 0x11111111 and 0x22222222 to TXDATA with out_ready=0 -> out_valid=1, out_data=0x11111111, tx_count=2. Then out_ready=1 for 2 cycles -> 0x11111111 then 0x22222222 delivered, out_valid=0.
- Write 9 words to TXDATA with out_ready=0 (DEPTH_LOG2=3) -> tx_full=1, tx_overflow=1, tx_count=8, ninth word never appears. Write 0x10 to STATUS -> tx_overflow=0.
- Push 0xDEADBEEF via in_valid, then read RXDATA -> 0xDEADBEEF returned, rx_empty=1. A second RXDATA read -> 0, rx_underflow=1.
- Fill RX to 8 words, then in_valid held with tx/rx flush written same cycle as a push -> in_ready=0 while full; after flush rx_count=0, pushed word discarded.
- With BUS_IO_RESPONDER_IRQ_EN: set irq_en, push one RX word -> irq=1 one cycle after rx_count becomes 1; read RXDATA -> irq=0 one cycle after rx_empty.

Source files
------------

// File: rtl/bus_io_responder.sv
// Purpose: CPU bus responder bridging loads/stores to a TX word FIFO (valid/ready out) and an RX word FIFO (valid/ready in).
// Latency: read data combinational in the cs cycle; pushes, pops, flushes and flag updates visible from the next cycle.
// Backpressure: out_valid = TX not empty; in_ready = RX not full (0 in reset); CPU never stalled, overflow/underflow flagged.
// Ports: clk, rst (async active-low); addr/cs/wr_rd/data_bus_write/data_bus_read CPU bus;
//        out_data/out_valid/out_ready TX consumer; in_data/in_valid/in_ready RX producer; irq.
// Optional feature macro: BUS_IO_RESPONDER_IRQ_EN (CTRL.irq_en and registered irq; otherwise irq tied 0).

// Generic word FIFO. Callers qualify push (not full) and pop (not empty); flush overrides both.
module bus_io_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [31:0]           push_dat,
  input  logic                  pop,
  input  logic                  flush,
  output logic [31:0]           head_dat,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly DEPTH_LOG2 bits, so plain increment wraps modulo depth.
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
endmodule

module bus_io_responder #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);
  localparam int CW = DEPTH_LOG2 + 1;

  logic [1:0]    sel;
  logic          bus_wr, bus_rd;
  logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [31:0]   rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf_set, rx_udf_set;
  logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic          irq_en_rd;
  logic [31:0]   status;
  logic          unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign sel    = addr[3:2];
  assign bus_wr = cs &  wr_rd;
  assign bus_rd = cs & !wr_rd;

  // A store to a full TX FIFO is dropped even if the consumer drains a word this same cycle.
  assign tx_push    = bus_wr && sel == 2'd0 && !tx_full;
  assign tx_ovf_set = bus_wr && sel == 2'd0 &&  tx_full;
  assign tx_pop     = out_valid & out_ready;
  assign tx_flush   = bus_wr && sel == 2'd3 && data_bus_write[0];

  assign rx_push    = in_valid & in_ready;
  assign rx_pop     = bus_rd && sel == 2'd1 && !rx_empty;
  assign rx_udf_set = bus_rd && sel == 2'd1 &&  rx_empty;
  assign rx_flush   = bus_wr && sel == 2'd3 && data_bus_write[1];

  bus_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_dat(data_bus_write), .pop(tx_pop),
    .flush(tx_flush), .head_dat(out_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  bus_io_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_dat(in_data), .pop(rx_pop),
    .flush(rx_flush), .head_dat(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign out_valid = !tx_empty;
  // Gated by rst directly so in_ready is low throughout reset and high the moment it releases.
  assign in_ready  = rst & !rx_full;

  // Sticky flags: a same-cycle set beats a W1C clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (bus_wr && sel == 2'd2 && data_bus_write[4]) tx_ovf_d = 1'b0;
    if (bus_wr && sel == 2'd2 && data_bus_write[5]) rx_udf_d = 1'b0;
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_udf_set) rx_udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

`ifdef BUS_IO_RESPONDER_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus_wr && sel == 2'd3) irq_en_d = data_bus_write[2];
    // Built from current status, so irq trails the status by one edge.
    irq_d = irq_en_q & (!rx_empty | tx_ovf_q | rx_udf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq       = irq_q;
  assign irq_en_rd = irq_en_q;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    status             = '0;
    status[0]          = tx_full;
    status[1]          = tx_empty;
    status[2]          = rx_full;
    status[3]          = rx_empty;
    status[4]          = tx_ovf_q;
    status[5]          = rx_udf_q;
    status[8  +: CW]   = tx_count;
    status[16 +: CW]   = rx_count;
  end

  always_comb begin
    data_bus_read = '0;
    if (bus_rd) begin
      case (sel)
        2'd1:    data_bus_read = rx_empty ? 32'd0 : rx_head;
        2'd2:    data_bus_read = status;
        2'd3:    data_bus_read = {29'd0, irq_en_rd, 2'b00};
        default: data_bus_read = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_io_responder.sv
// Bench for bus_io_responder: queue-based reference model, per-cycle compare, directed literals and random traffic.
module tb_bus_io_responder;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        irq;

  bus_io_responder #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .cs(cs), .wr_rd(wr_rd),
    .data_bus_write(data_bus_write), .data_bus_read(data_bus_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, flags as bits.
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          ovf_m, udf_m, irq_en_m, irq_m;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] exp_read();
    logic [31:0] s;
    s = 32'd0;
    if (!cs || wr_rd) return 32'd0;
    case (addr[3:2])
      2'd1: s = (rx_q.size() != 0) ? rx_q[0] : 32'd0;
      2'd2: begin
        s = (32'(tx_q.size()) << 8) + (32'(rx_q.size()) << 16);
        if (tx_q.size() == DEPTH) s = s + 32'h1;
        if (tx_q.size() == 0)     s = s + 32'h2;
        if (rx_q.size() == DEPTH) s = s + 32'h4;
        if (rx_q.size() == 0)     s = s + 32'h8;
        if (ovf_m)                s = s + 32'h10;
        if (udf_m)                s = s + 32'h20;
      end
      2'd3: s = irq_en_m ? 32'h4 : 32'h0;
      default: s = 32'd0;
    endcase
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int          tx_n, rx_n;
    logic [1:0]  sel;
    bit          wr_hit, rd_hit, ovf_set, udf_set;
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      ovf_m = 0; udf_m = 0; irq_en_m = 0; irq_m = 0;
    end else begin
      tx_n   = tx_q.size();
      rx_n   = rx_q.size();
      sel    = addr[3:2];
      wr_hit = cs && wr_rd;
      rd_hit = cs && !wr_rd;
`ifdef BUS_IO_RESPONDER_IRQ_EN
      irq_m  = irq_en_m && (rx_n != 0 || ovf_m || udf_m);
`endif
      ovf_set = wr_hit && sel == 2'd0 && tx_n == DEPTH;
      udf_set = rd_hit && sel == 2'd1 && rx_n == 0;
      if (out_ready && tx_n != 0) void'(tx_q.pop_front());
      if (wr_hit && sel == 2'd0 && tx_n < DEPTH) tx_q.push_back(data_bus_write);
      if (rd_hit && sel == 2'd1 && rx_n != 0) void'(rx_q.pop_front());
      if (in_valid && rx_n < DEPTH) rx_q.push_back(in_data);
      if (wr_hit && sel == 2'd3) begin
        if (data_bus_write[0]) tx_q.delete();
        if (data_bus_write[1]) rx_q.delete();
`ifdef BUS_IO_RESPONDER_IRQ_EN
        irq_en_m = data_bus_write[2];
`endif
      end
      ovf_m = ovf_set || (ovf_m && !(wr_hit && sel == 2'd2 && data_bus_write[4]));
      udf_m = udf_set || (udf_m && !(wr_hit && sel == 2'd2 && data_bus_write[5]));
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0) check("out_data", out_data, tx_q[0]);
      check("in_ready", 32'(in_ready), 32'(rst && rx_q.size() < DEPTH));
      check("data_bus_read", data_bus_read, exp_read());
      check("irq", 32'(irq), 32'(irq_m));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
    step();
    cs = 1'b0; wr_rd = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    cs = 1'b1; wr_rd = 1'b0; addr = a;
    @(negedge clk);
    check(nm, data_bus_read, exp);
    step();
    cs = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    step();
    rst = 1'b1;

    // Post-reset status
    rd_chk(32'h8, 32'h0000000A, "status_after_reset");
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Two TX words then drain
    bus_wr(32'h0, 32'h11111111);
    bus_wr(32'h0, 32'h22222222);
    @(negedge clk);
    check("tx_head_valid", 32'(out_valid), 32'd1);
    check("tx_head_data", out_data, 32'h11111111);
    step();
    rd_chk(32'h8, 32'h00000208, "status_tx2");
    out_ready = 1'b1;
    @(negedge clk);
    check("tx_drain0", out_data, 32'h11111111);
    step();
    @(negedge clk);
    check("tx_drain1", out_data, 32'h22222222);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("tx_drained_valid", 32'(out_valid), 32'd0);
    step();

    // TX overflow
    for (int i = 0; i < 9; i++) bus_wr(32'h0, 32'h100 + 32'(i));
    rd_chk(32'h8, 32'h00000819, "status_tx_full_ovf");
    bus_wr(32'h8, 32'h10);
    rd_chk(32'h8, 32'h00000809, "status_ovf_cleared");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tx_full_drain", out_data, 32'h100 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("ninth_word_absent", 32'(out_valid), 32'd0);
    step();

    // RX single word and underflow
    in_data = 32'hDEADBEEF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rd_chk(32'h4, 32'hDEADBEEF, "rx_read");
    rd_chk(32'h8, 32'h0000000A, "status_rx_empty");
    rd_chk(32'h4, 32'h0, "rx_read_empty");
    rd_chk(32'h8, 32'h0000002A, "status_udf");
    bus_wr(32'h8, 32'h20);
    rd_chk(32'h8, 32'h0000000A, "status_udf_cleared");

    // RX fill and flush
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h200 + 32'(i);
      step();
    end
    @(negedge clk);
    check("rx_full_in_ready", 32'(in_ready), 32'd0);
    step();
    rd_chk(32'h8, 32'h00080006, "status_rx_full");
    in_data = 32'h2FF;
    bus_wr(32'hC, 32'h3);
    in_valid = 1'b0;
    rd_chk(32'h8, 32'h0000000A, "status_after_flush");
    in_data = 32'h300; in_valid = 1'b1;
    step();
    in_data = 32'h301;
    bus_wr(32'hC, 32'h2);
    in_valid = 1'b0;
    rd_chk(32'h8, 32'h0000000A, "flush_beats_push");

`ifdef BUS_IO_RESPONDER_IRQ_EN
    bus_wr(32'hC, 32'h4);
    rd_chk(32'hC, 32'h4, "ctrl_irq_en");
    in_data = 32'h400; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("irq_lag", 32'(irq), 32'd0);
    step();
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    step();
    rd_chk(32'h4, 32'h400, "irq_rx_read");
    @(negedge clk);
    check("irq_hold", 32'(irq), 32'd1);
    step();
    @(negedge clk);
    check("irq_clear", 32'(irq), 32'd0);
    step();
    bus_wr(32'hC, 32'h0);
`else
    bus_wr(32'hC, 32'h4);
    rd_chk(32'hC, 32'h0, "ctrl_no_irq_en");
    @(negedge clk);
    check("irq_tied", 32'(irq), 32'd0);
    step();
`endif

    // Random traffic, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b0;
      if (i == 1503) rst = 1'b1;
      cs             = 1'($urandom_range(0, 1));
      wr_rd          = 1'($urandom_range(0, 1));
      addr           = $urandom;
      data_bus_write = $urandom;
      if (addr[3:2] == 2'd3 && $urandom_range(0, 7) != 0) data_bus_write[1:0] = 2'b00;
      in_valid       = 1'($urandom_range(0, 1));
      in_data        = $urandom;
      out_ready      = (i < 1000) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      step();
    end

    cs = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
